// File: rtl/mf_template_injector.sv
// mf_template_injector: adds the time-reversed 42-tap matched-filter
// template into one channel's 8-lane SSR stream for calibration.
// Ports: aclk, aresetn (async, active-low); data_i/data_o live and
//   injected samples, lane i at [NBITS*i +: NBITS], 1-clock latency;
//   trig_i/phase_i/shift_i start a play; busy_o, done_o, trig_lost_o.
// Option: MF_INJ_SATURATE_EN -> saturating add plus sticky sat_o.
module mf_template_injector #(
  parameter int NBITS  = 12,
  parameter int NSAMPS = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NBITS*NSAMPS-1:0] data_i,
  input  logic                    trig_i,
  input  logic [2:0]              phase_i,
  input  logic [3:0]              shift_i,
  output logic [NBITS*NSAMPS-1:0] data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    trig_lost_o
`ifdef MF_INJ_SATURATE_EN
  ,
  output logic [NSAMPS-1:0]       sat_o
`endif
);

  localparam int TLEN = 42;
  localparam logic [3:0] SMAX = 4'(NBITS - 4);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] beat_q;
  logic [2:0] phase_q;
  logic [3:0] shift_q;

  function automatic logic signed [3:0] tmpl(
    input logic [5:0] k
  );
    unique case (k)
      6'd0, 6'd1, 6'd4, 6'd6, 6'd17, 6'd19,
      6'd25, 6'd26, 6'd27, 6'd28, 6'd35, 6'd36:
        tmpl = 4'sd1;
      6'd2, 6'd15, 6'd21, 6'd22, 6'd23,
      6'd30, 6'd31, 6'd32, 6'd40, 6'd41:
        tmpl = -4'sd1;
      6'd3, 6'd13, 6'd14: tmpl = -4'sd2;
      6'd11, 6'd18:       tmpl = 4'sd2;
      6'd5, 6'd10:        tmpl = 4'sd4;
      6'd7, 6'd8:         tmpl = -4'sd4;
      default:            tmpl = 4'sd0;
    endcase
  endfunction

  logic       accept;
  logic       inj_en;
  logic [2:0] cur_beat;
  logic [2:0] cur_phase;
  logic [3:0] cur_shift;
  logic [3:0] shift_in;
  logic [2:0] last_beat;

  // DONE accepts a new trigger so back-to-back plays have no gap.
  assign accept    = trig_i && (state != PLAY);
  assign inj_en    = accept || (state == PLAY);
  assign shift_in  = (shift_i > SMAX) ? SMAX : shift_i;
  // Beat 0 uses the live request so it lands with the trigger.
  assign cur_beat  = accept ? 3'd0 : beat_q;
  assign cur_phase = accept ? phase_i : phase_q;
  assign cur_shift = accept ? shift_in : shift_q;
  assign last_beat = (phase_q == 3'd7) ? 3'd6 : 3'd5;

  logic [NBITS*NSAMPS-1:0] data_nxt;
`ifdef MF_INJ_SATURATE_EN
  logic [NSAMPS-1:0] clip;
`else
  logic [NSAMPS-1:0] unused_msb;
`endif

  always_comb begin
    logic [6:0]            slot;
    logic [6:0]            k;
    logic signed [3:0]     t;
    logic signed [NBITS:0] inj;
    logic signed [NBITS:0] sum;
    data_nxt = '0;
    slot     = '0;
    k        = '0;
    t        = '0;
    inj      = '0;
    sum      = '0;
`ifdef MF_INJ_SATURATE_EN
    clip = '0;
`else
    unused_msb = '0;
`endif
    for (int l = 0; l < NSAMPS; l++) begin
      // Stream slot of this lane; template index = slot - phase.
      slot = {1'b0, cur_beat, 3'(l)};
      k    = slot - {4'd0, cur_phase};
      t    = tmpl(k[5:0]);
      inj  = '0;
      if (inj_en && slot >= {4'd0, cur_phase}
          && k < 7'(TLEN))
        inj = {{(NBITS-3){t[3]}}, t} << cur_shift;
      sum = $signed({data_i[NBITS*l+NBITS-1],
                     data_i[NBITS*l +: NBITS]}) + inj;
`ifdef MF_INJ_SATURATE_EN
      if (sum[NBITS] != sum[NBITS-1]) begin
        clip[l] = 1'b1;
        data_nxt[NBITS*l +: NBITS] = sum[NBITS]
          ? {1'b1, {(NBITS-1){1'b0}}}
          : {1'b0, {(NBITS-1){1'b1}}};
      end else begin
        data_nxt[NBITS*l +: NBITS] = sum[NBITS-1:0];
      end
`else
      unused_msb[l] = sum[NBITS];
      data_nxt[NBITS*l +: NBITS] = sum[NBITS-1:0];
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      beat_q      <= '0;
      phase_q     <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      trig_lost_o <= 1'b0;
    end else begin
      data_o      <= data_nxt;
      done_o      <= 1'b0;
      trig_lost_o <= 1'b0;
      if (accept) begin
        phase_q <= phase_i;
        shift_q <= shift_in;
      end
      unique case (state)
        IDLE: begin
          if (trig_i) begin
            state  <= PLAY;
            beat_q <= 3'd1;
            busy_o <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        PLAY: begin
          trig_lost_o <= trig_i;
          beat_q      <= beat_q + 3'd1;
          if (beat_q == last_beat)
            state <= DONE;
        end
        DONE: begin
          done_o <= 1'b1;
          if (trig_i) begin
            state  <= PLAY;
            beat_q <= 3'd1;
            busy_o <= 1'b1;
          end else begin
            state  <= IDLE;
            beat_q <= '0;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MF_INJ_SATURATE_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      sat_o <= '0;
    else
      sat_o <= (accept ? '0 : sat_o) | clip;
  end
`endif

endmodule
